// File: rtl/frame_draw_sequencer.sv
// Per-frame scheduler for the shared frame-buffer write port. Starts the enabled
// draw engines one at a time in index order, routes the active engine onto the
// frame buffer, then flips the double-buffer select and reports frame completion.
module frame_draw_sequencer #(
  parameter int unsigned NUM_ENG = 3,
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 200000,
  parameter int unsigned TO_W    = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_trig,
  input  logic [NUM_ENG-1:0]        eng_en,
  input  logic                      err_clr,
  output logic [NUM_ENG-1:0]        eng_start,
  input  logic [NUM_ENG-1:0]        eng_done,
  input  logic [NUM_ENG-1:0]        eng_we,
  input  logic [NUM_ENG*ADDR_W-1:0] eng_addr,
  input  logic [NUM_ENG*DATA_W-1:0] eng_data,
  output logic [NUM_ENG-1:0]        eng_rdy,
  output logic                      fb_we,
  output logic [ADDR_W-1:0]         fb_addr,
  output logic [DATA_W-1:0]         fb_data,
  input  logic                      fb_rdy,
  output logic                      buf_sel,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      timeout_err,
  output logic                      overrun_err
);

  localparam int unsigned IdxW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StNext,
    StSwap
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [NUM_ENG-1:0]  mask_q, mask_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                buf_sel_q, buf_sel_d;
  logic                timeout_err_q, timeout_err_d;
  logic                overrun_err_q, overrun_err_d;

  logic                first_found;
  logic [IdxW-1:0]     first_idx;
  logic                next_found;
  logic [IdxW-1:0]     next_idx;
  logic                act_done;
  logic                to_hit;
  logic                to_set;
  logic                ov_set;

  // Priority search: lowest enabled engine for a new frame, lowest masked engine above idx.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = int'(NUM_ENG) - 1; i >= 0; i--) begin
      if (eng_en[i]) begin
        first_found = 1'b1;
        first_idx   = IdxW'(i);
      end
      if (mask_q[i] && (i > int'(idx_q))) begin
        next_found = 1'b1;
        next_idx   = IdxW'(i);
      end
    end
  end

  assign act_done = eng_done[idx_q];
  assign to_hit   = (to_cnt_q == TO_W'(TIMEOUT - 1));

  // Next-state logic for the frame sequencing FSM and its datapath registers.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    to_cnt_d  = to_cnt_q;
    buf_sel_d = buf_sel_q;
    to_set    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_trig) begin
          mask_d = eng_en;
          if (first_found) begin
            idx_d   = first_idx;
            state_d = StStart;
          end else begin
            state_d = StSwap;
          end
        end
      end
      StStart: begin
        to_cnt_d = '0;
        state_d  = StRun;
      end
      StRun: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // A done in the final allowed cycle is a normal finish, not an abort.
        if (act_done) begin
          state_d = StNext;
        end else if (to_hit) begin
          to_set  = 1'b1;
          state_d = StNext;
        end
      end
      StNext: begin
        if (next_found) begin
          idx_d   = next_idx;
          state_d = StStart;
        end else begin
          state_d = StSwap;
        end
      end
      StSwap: begin
        buf_sel_d = ~buf_sel_q;
        mask_d    = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky error flags; a new error event takes precedence over a clear.
  always_comb begin
    ov_set        = frame_trig && (state_q != StIdle);
    timeout_err_d = to_set | (timeout_err_q & ~err_clr);
    overrun_err_d = ov_set | (overrun_err_q & ~err_clr);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      mask_q        <= '0;
      to_cnt_q      <= '0;
      buf_sel_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      mask_q        <= mask_d;
      to_cnt_q      <= to_cnt_d;
      buf_sel_q     <= buf_sel_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // Output decode: start pulse, frame-buffer routing and status from state/idx.
  always_comb begin
    eng_start  = '0;
    eng_rdy    = '0;
    fb_we      = 1'b0;
    fb_addr    = '0;
    fb_data    = '0;
    frame_done = (state_q == StSwap);
    busy       = (state_q != StIdle);
    unique case (state_q)
      StStart: eng_start[idx_q] = 1'b1;
      StRun: begin
        fb_we          = eng_we[idx_q];
        fb_addr        = eng_addr[idx_q*ADDR_W +: ADDR_W];
        fb_data        = eng_data[idx_q*DATA_W +: DATA_W];
        eng_rdy[idx_q] = fb_rdy;
      end
      default: ;
    endcase
  end

  assign buf_sel     = buf_sel_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Randomized scoreboard bench for frame_draw_sequencer. A frame-level reference
// model predicts start/done event times and per-cycle routing and flag values.
module tb_frame_draw_sequencer;

  localparam int NE = 3;
  localparam int AW = 17;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_trig;
  logic [NE-1:0]     eng_en;
  logic              err_clr;
  logic [NE-1:0]     eng_start;
  logic [NE-1:0]     eng_done;
  logic [NE-1:0]     eng_we;
  logic [NE*AW-1:0]  eng_addr;
  logic [NE*DW-1:0]  eng_data;
  logic [NE-1:0]     eng_rdy;
  logic              fb_we;
  logic [AW-1:0]     fb_addr;
  logic [DW-1:0]     fb_data;
  logic              fb_rdy;
  logic              buf_sel;
  logic              frame_done;
  logic              busy;
  logic              timeout_err;
  logic              overrun_err;

  frame_draw_sequencer #(
    .NUM_ENG (NE),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO),
    .TO_W    (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_trig  (frame_trig),
    .eng_en      (eng_en),
    .err_clr     (err_clr),
    .eng_start   (eng_start),
    .eng_done    (eng_done),
    .eng_we      (eng_we),
    .eng_addr    (eng_addr),
    .eng_data    (eng_data),
    .eng_rdy     (eng_rdy),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_rdy      (fb_rdy),
    .buf_sel     (buf_sel),
    .frame_done  (frame_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame schedule written by the stimulus; each engine k runs in cycles (s_c, e_c].
  int  f_trig, f_done;
  int  f_gen = 0;
  int  kill_gen = -1;
  bit  f_valid = 1'b0;
  int  s_c[NE];
  int  e_c[NE];
  bit  en_m[NE];
  bit  ab_m[NE];

  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] cyc;
    logic [3:0]  val;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  bit m_buf = 1'b0;
  bit m_to  = 1'b0;
  bit m_ov  = 1'b0;

  function automatic bit live();
    return f_valid && (kill_gen != f_gen);
  endfunction

  function automatic int run_eng();
    for (int k = 0; k < NE; k++)
      if (live() && en_m[k] && cyc > s_c[k] && cyc <= e_c[k]) return k;
    return -1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: event scoreboard plus per-cycle routing/flag comparison, then model update.
  always @(negedge clk) begin : mon
    int            r;
    bit            bz;
    bit            set_to;
    logic          we_e;
    logic [AW-1:0] addr_e;
    logic [DW-1:0] data_e;
    logic [NE-1:0] rdy_e;
    ev_t           ev;

    if (eng_start != '0) begin
      if (exp_q.size() == 0) chk("start_unexpected", 64'(eng_start), 64'(0));
      else begin
        ev = exp_q.pop_front();
        chk("start_event", 64'({4'd0, 32'(cyc), 1'b0, eng_start}), 64'(ev));
      end
    end
    if (frame_done) begin
      if (exp_q.size() == 0) chk("done_unexpected", 64'(frame_done), 64'(0));
      else begin
        ev = exp_q.pop_front();
        chk("done_event", 64'({4'd1, 32'(cyc), 4'd0}), 64'(ev));
      end
    end

    r      = run_eng();
    bz     = live() && cyc > f_trig && cyc <= f_done;
    we_e   = 1'b0;
    addr_e = '0;
    data_e = '0;
    rdy_e  = '0;
    if (r >= 0) begin
      we_e     = eng_we[r];
      addr_e   = eng_addr[r*AW +: AW];
      data_e   = eng_data[r*DW +: DW];
      rdy_e[r] = fb_rdy;
    end
    chk("route", 64'({busy, fb_we, fb_addr, fb_data, eng_rdy}),
        64'({bz, we_e, addr_e, data_e, rdy_e}));
    chk("flags", 64'({buf_sel, timeout_err, overrun_err}), 64'({m_buf, m_to, m_ov}));
    if (live() && cyc == f_done + 1) chk("leftover_events", 64'(exp_q.size()), 64'(0));

    set_to = 1'b0;
    for (int k = 0; k < NE; k++)
      if (live() && en_m[k] && ab_m[k] && cyc == e_c[k]) set_to = 1'b1;
    if (rst) begin
      m_buf    = 1'b0;
      m_to     = 1'b0;
      m_ov     = 1'b0;
      kill_gen = f_gen;
      exp_q.delete();
    end else begin
      m_to = set_to | (m_to & ~err_clr);
      m_ov = (frame_trig && bz) | (m_ov & ~err_clr);
      if (live() && cyc == f_done) m_buf = ~m_buf;
    end
  end

  // Engine responder: done at the scheduled finish, random spurious dones elsewhere.
  initial begin
    eng_done = '0;
    eng_we   = '0;
    eng_addr = '0;
    eng_data = '0;
    fb_rdy   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NE; k++) begin
        bit v;
        v = live() && en_m[k] && !ab_m[k] && cyc == e_c[k];
        if (!v && !(live() && en_m[k] && cyc > s_c[k] && cyc <= e_c[k]))
          v = ($urandom_range(0, 9) == 0);
        eng_done[k] = v;
      end
      eng_we   = NE'($urandom);
      eng_addr = (NE*AW)'({$urandom, $urandom});
      eng_data = (NE*DW)'({$urandom, $urandom, $urandom});
      fb_rdy   = 1'($urandom);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    frame_trig = 1'b0;
    err_clr    = 1'b0;
    rst        = 1'b0;
    eng_en     = NE'($urandom);
  endtask

  // Issue a trigger now and record the predicted schedule (delay > TO means never done).
  task automatic start_frame(logic [NE-1:0] mask, int d0, int d1, int d2);
    int  dl[NE];
    int  t;
    int  d;
    ev_t ev;
    dl[0] = d0;
    dl[1] = d1;
    dl[2] = d2;
    step();
    t = cyc + 1;
    for (int k = 0; k < NE; k++) begin
      en_m[k] = mask[k];
      ab_m[k] = 1'b0;
      s_c[k]  = -10;
      e_c[k]  = -10;
      if (mask[k]) begin
        d       = (dl[k] > TO) ? TO : dl[k];
        ab_m[k] = (dl[k] > TO);
        s_c[k]  = t;
        e_c[k]  = t + d;
        ev      = {4'd0, 32'(t), 4'(1 << k)};
        exp_q.push_back(ev);
        t       = t + d + 2;
      end
    end
    f_trig = cyc;
    f_done = t;
    ev     = {4'd1, 32'(t), 4'd0};
    exp_q.push_back(ev);
    f_gen++;
    f_valid    = 1'b1;
    frame_trig = 1'b1;
    eng_en     = mask;
  endtask

  // Run to one cycle past frame_done, sprinkling overrun triggers and error clears.
  task automatic wait_frame();
    while (cyc <= f_done + 1) begin
      step();
      if (cyc > f_trig && cyc <= f_done && $urandom_range(0, 29) == 0) frame_trig = 1'b1;
      if ($urandom_range(0, 24) == 0) err_clr = 1'b1;
    end
  endtask

  function automatic int rd();
    return ($urandom_range(0, 5) == 0) ? 999 : int'($urandom_range(1, 20));
  endfunction

  initial begin
    rst        = 1'b1;
    frame_trig = 1'b0;
    err_clr    = 1'b0;
    eng_en     = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    step();
    repeat (3) step();

    start_frame(3'b111, 10, 10, 10);
    wait_frame();
    start_frame(3'b111, 10, 10, 10);
    wait_frame();
    start_frame(3'b101, rd(), rd(), rd());
    wait_frame();
    start_frame(3'b000, 1, 1, 1);
    wait_frame();
    start_frame(3'b111, 999, 4, 7);
    wait_frame();
    step();
    err_clr = 1'b1;
    step();
    start_frame(3'b111, 16, 3, 16);
    wait_frame();

    // Reset in the middle of engine 1's run, then a clean frame.
    start_frame(3'b111, 10, 10, 10);
    while (cyc < s_c[1] + 3) step();
    rst = 1'b1;
    step();
    repeat (5) step();
    start_frame(3'b111, 5, 5, 5);
    wait_frame();

    for (int n = 0; n < 40; n++) begin
      start_frame(NE'($urandom), rd(), rd(), rd());
      wait_frame();
    end
    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
